// File: rtl/alu_sequencer.sv
// alu_sequencer: takes header/A/B command bytes, fires the ALU once, waits ALU_LAT cycles,
// then returns the captured result over a valid/ready output.
module alu_sequencer #(
   parameter int         ALU_LAT = 1,
   parameter logic [1:0] SYNC    = 2'b10
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] IN_DAT,
   input  logic       IN_VLD,
   output logic       IN_RDY,
   output logic       ALU_ENA,
   output logic [3:0] ALU_OPT,
   output logic [1:0] ALU_KEY,
   output logic [7:0] ALU_RGA,
   output logic [7:0] ALU_RGB,
   input  logic [7:0] ALU_RGZ,
   output logic [7:0] OUT_DAT,
   output logic       OUT_VLD,
   input  logic       OUT_RDY,
   output logic       ERR
);
   typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, WAIT, DONE} state_t;
   state_t     state;
   logic [3:0] cnt;
   logic       xfer;
   assign xfer = IN_VLD & IN_RDY;
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         IN_RDY  <= 1'b0;
         ALU_ENA <= 1'b0;
         ALU_OPT <= 4'd0;
         ALU_KEY <= 2'd0;
         ALU_RGA <= 8'd0;
         ALU_RGB <= 8'd0;
         OUT_DAT <= 8'd0;
         OUT_VLD <= 1'b0;
         ERR     <= 1'b0;
      end else begin
         ALU_ENA <= 1'b0;
         case (state)
            IDLE: begin
               IN_RDY <= 1'b1;
               if (xfer && IN_DAT[5:4] == SYNC) begin
                  ALU_KEY <= IN_DAT[7:6];
                  ALU_OPT <= IN_DAT[3:0];
                  state   <= GET_A;
               end else if (xfer) begin
                  ERR <= 1'b1;
               end
            end
            GET_A: begin
               IN_RDY <= 1'b1;
               if (xfer) begin
                  ALU_RGA <= IN_DAT;
                  state   <= GET_B;
               end
            end
            GET_B: begin
               IN_RDY <= ~xfer;
               if (xfer) begin
                  ALU_RGB <= IN_DAT;
                  ALU_ENA <= 1'b1;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               cnt   <= 4'(ALU_LAT);
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               // counter reaching 1 marks the edge exactly ALU_LAT cycles after the enable
               if (cnt == 4'd1) begin
                  OUT_DAT <= ALU_RGZ;
                  OUT_VLD <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (OUT_RDY) begin
                  OUT_VLD <= 1'b0;
                  IN_RDY  <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: two sequencers (ALU_LAT 1 and 4) against a command-level model,
// with a latency-exact ALU model whose result is valid only in the cycle ALU_LAT after enable.
module tb_alu_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;
   logic [1:0] in_vld, in_rdy, alu_ena, out_vld, out_rdy, err;
   logic [1:0][7:0] in_dat, alu_rga, alu_rgb, rgz, out_dat;
   logic [1:0][3:0] alu_opt;
   logic [1:0][1:0] alu_key;

   alu_sequencer #(.ALU_LAT(1)) u0 (
      .CLK(clk), .RST(rst), .IN_DAT(in_dat[0]), .IN_VLD(in_vld[0]), .IN_RDY(in_rdy[0]),
      .ALU_ENA(alu_ena[0]), .ALU_OPT(alu_opt[0]), .ALU_KEY(alu_key[0]), .ALU_RGA(alu_rga[0]),
      .ALU_RGB(alu_rgb[0]), .ALU_RGZ(rgz[0]), .OUT_DAT(out_dat[0]), .OUT_VLD(out_vld[0]),
      .OUT_RDY(out_rdy[0]), .ERR(err[0]));
   alu_sequencer #(.ALU_LAT(4)) u1 (
      .CLK(clk), .RST(rst), .IN_DAT(in_dat[1]), .IN_VLD(in_vld[1]), .IN_RDY(in_rdy[1]),
      .ALU_ENA(alu_ena[1]), .ALU_OPT(alu_opt[1]), .ALU_KEY(alu_key[1]), .ALU_RGA(alu_rga[1]),
      .ALU_RGB(alu_rgb[1]), .ALU_RGZ(rgz[1]), .OUT_DAT(out_dat[1]), .OUT_VLD(out_vld[1]),
      .OUT_RDY(out_rdy[1]), .ERR(err[1]));

   int tests = 0, fails = 0, cyc = 0;
   int nb[2], age[2], aage[2], omode[2], ena_cnt[2], ena_t[2], vld_cnt[2], vld_t[2];
   logic [7:0] e_a[2], e_b[2], e_dat[2];
   logic [3:0] e_opt[2];
   logic [1:0] e_key[2];
   logic e_rdy[2], e_ena[2], e_vld[2], e_err[2], pv[2];

   function automatic int lat(input int d);
      return d ? 4 : 1;
   endfunction

   function automatic logic [7:0] fn(input logic [3:0] o, input logic [1:0] k,
                                     input logic [7:0] a, input logic [7:0] b);
      return (o == 4'd0) ? 8'(a + b) : 8'((a ^ b) + {o, 2'b00, k});
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // command-level model: bytes received so far, then edges elapsed since operand B
   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         logic x;
         int l;
         l = lat(d);
         x = in_vld[d] & e_rdy[d];
         e_ena[d] = 1'b0;
         if (rst) begin
            nb[d] = 0; age[d] = 0; e_rdy[d] = 0; e_opt[d] = 0; e_key[d] = 0;
            e_a[d] = 0; e_b[d] = 0; e_dat[d] = 0; e_vld[d] = 0; e_err[d] = 0;
         end else if (age[d] == 0) begin
            if (x && nb[d] == 0) begin
               if (in_dat[d][5:4] == 2'b10) begin
                  e_key[d] = in_dat[d][7:6];
                  e_opt[d] = in_dat[d][3:0];
                  nb[d] = 1;
               end else e_err[d] = 1'b1;
            end else if (x && nb[d] == 1) begin
               e_a[d] = in_dat[d];
               nb[d] = 2;
            end else if (x && nb[d] == 2) begin
               e_b[d] = in_dat[d];
               nb[d] = 0;
               age[d] = 1;
               e_ena[d] = 1'b1;
            end
            e_rdy[d] = (age[d] == 0);
         end else if (age[d] <= l) age[d]++;
         else if (age[d] == l + 1) begin
            e_dat[d] = rgz[d];
            e_vld[d] = 1'b1;
            age[d]++;
         end else if (out_rdy[d]) begin
            e_vld[d] = 1'b0;
            age[d] = 0;
            e_rdy[d] = 1'b1;
         end
      end
   endtask

   task automatic compare_step();
      cyc++;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d in_rdy", d), in_rdy[d], e_rdy[d]);
         chk($sformatf("d%0d alu_ena", d), alu_ena[d], e_ena[d]);
         chk($sformatf("d%0d alu_opt", d), alu_opt[d], e_opt[d]);
         chk($sformatf("d%0d alu_key", d), alu_key[d], e_key[d]);
         chk($sformatf("d%0d alu_rga", d), alu_rga[d], e_a[d]);
         chk($sformatf("d%0d alu_rgb", d), alu_rgb[d], e_b[d]);
         chk($sformatf("d%0d out_dat", d), out_dat[d], e_dat[d]);
         chk($sformatf("d%0d out_vld", d), out_vld[d], e_vld[d]);
         chk($sformatf("d%0d err", d), err[d], e_err[d]);
         if (alu_ena[d]) begin ena_cnt[d]++; ena_t[d] = cyc; end
         if (out_vld[d]) vld_cnt[d]++;
         if (out_vld[d] && !pv[d]) vld_t[d] = cyc;
         pv[d] = out_vld[d];
      end
   endtask

   // ALU whose result is valid only in the cycle exactly ALU_LAT after the enable cycle
   task automatic drive_step();
      for (int d = 0; d < 2; d++) begin
         logic [7:0] r;
         if (rst) aage[d] = 99;
         else if (alu_ena[d]) aage[d] = 0;
         else if (aage[d] < 99) aage[d]++;
         r = fn(alu_opt[d], alu_key[d], alu_rga[d], alu_rgb[d]);
         rgz[d] = (aage[d] == lat(d)) ? r : r ^ 8'($urandom_range(1, 255));
         out_rdy[d] = (omode[d] == 2) ? 1'($urandom) : (omode[d] == 1);
      end
   endtask

   task automatic send(input int d, input logic [7:0] b);
      int n = 0;
      in_dat[d] = b;
      in_vld[d] = 1'b1;
      while (!in_rdy[d] && n < 200) begin @(negedge clk); n++; end
      chk("send handshake", in_rdy[d], 1);
      @(negedge clk);
      in_vld[d] = 1'b0;
   endtask

   task automatic wait_vld(input int d);
      int n = 0;
      while (!out_vld[d] && n < 100) begin @(negedge clk); n++; end
      chk("result timeout", out_vld[d], 1);
      #1;
   endtask

   initial begin
      int e0, p;
      logic [7:0] h;
      rst = 1'b1; in_vld = '0; in_dat = '0; rgz = '0; out_rdy = 2'b11;
      omode = '{1, 1}; aage = '{99, 99};
      ena_cnt = '{0, 0}; vld_cnt = '{0, 0}; ena_t = '{0, 0}; vld_t = '{0, 0}; pv = '{0, 0};
      fork
         forever @(posedge clk) model_step();
         forever @(negedge clk) compare_step();
         forever @(negedge clk) drive_step();
      join_none
      repeat (3) @(negedge clk);
      chk("reset in_rdy", in_rdy[0], 0);
      rst = 1'b0;
      @(negedge clk);
      chk("reset out_vld", out_vld[0], 0);
      // basic add, latency 1
      send(0, 8'h60); send(0, 8'h07); send(0, 8'h05);
      wait_vld(0);
      chk("add rga", alu_rga[0], 8'h07);
      chk("add rgb", alu_rgb[0], 8'h05);
      chk("add opt", alu_opt[0], 0);
      chk("add key", alu_key[0], 1);
      chk("add dat", out_dat[0], 8'h0C);
      chk("add ena count", ena_cnt[0], 1);
      chk("lat1 timing", vld_t[0] - ena_t[0], 2);
      @(negedge clk);
      // latency 4
      send(1, 8'hA3); send(1, 8'h10); send(1, 8'h22);
      wait_vld(1);
      chk("lat4 dat", out_dat[1], 8'h64);
      chk("lat4 timing", vld_t[1] - ena_t[1], 5);
      @(negedge clk);
      // bad header then a good command
      send(0, 8'h03);
      chk("bad hdr err", err[0], 1);
      chk("bad hdr idle", in_rdy[0], 1);
      send(0, 8'h20); send(0, 8'h01); send(0, 8'h02);
      wait_vld(0);
      chk("after err dat", out_dat[0], 8'h03);
      chk("err sticky", err[0], 1);
      @(negedge clk);
      // gapped input and output backpressure
      omode[0] = 0;
      e0 = ena_cnt[0];
      send(0, 8'h61); send(0, 8'h30);
      repeat (5) @(negedge clk);
      send(0, 8'h0F);
      wait_vld(0);
      repeat (10) @(negedge clk);
      chk("bp vld held", out_vld[0], 1);
      chk("bp dat held", out_dat[0], 8'h50);
      chk("bp rdy low", in_rdy[0], 0);
      chk("bp single ena", ena_cnt[0], e0 + 1);
      omode[0] = 1;
      repeat (3) @(negedge clk);
      // reset mid-command
      send(0, 8'h20); send(0, 8'h55);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid rst rga", alu_rga[0], 0);
      chk("mid rst opt", alu_opt[0], 0);
      chk("mid rst dat", out_dat[0], 0);
      chk("mid rst err", err[0], 0);
      chk("mid rst rdy", in_rdy[0], 0);
      send(0, 8'h20); send(0, 8'h0A); send(0, 8'h0B);
      wait_vld(0);
      chk("post rst rga", alu_rga[0], 8'h0A);
      chk("post rst dat", out_dat[0], 8'h15);
      @(negedge clk);
      // back-to-back commands
      e0 = ena_cnt[0];
      p = vld_cnt[0];
      send(0, 8'h21); send(0, 8'h03); send(0, 8'h04);
      send(0, 8'h22); send(0, 8'h05); send(0, 8'h06);
      wait_vld(0);
      @(negedge clk);
      chk("b2b ena pulses", ena_cnt[0], e0 + 2);
      chk("b2b vld cycles", vld_cnt[0], p + 2);
      chk("b2b last dat", out_dat[0], 8'h23);
      // random traffic on both instances
      omode = '{2, 2};
      repeat (60) begin
         int d;
         d = int'($urandom_range(0, 1));
         h = 8'($urandom);
         if ($urandom_range(0, 4) != 0) h[5:4] = 2'b10;
         send(d, h);
         if (h[5:4] == 2'b10) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(d, 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(d, 8'($urandom));
         end
      end
      omode = '{1, 1};
      repeat (40) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
